vx_mem_arb_tracked: RTL

- N-input memory-request arbiter with per-input outstanding-read tracking; successor of the fixed 2-input L1 arbiter at socket level.
- Merges icache, dcache and future L1 clients (tex, raster, etc.) onto one line-sized memory bus.
- Appends the source index to the request tag and routes responses back by that index.
- Adds selectable arbitration mode, per-input credit limiting, a registered output stage and a socket-level busy indication.

---
 rtl/vx_mem_arb_tracked_if.sv | 68 ++++++
 rtl/vx_mem_arb_tracked.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_arb_tracked_if.sv
// Bus bundle for vx_mem_arb_tracked.
// Request side: NUM_INPUTS flattened client lanes in, one merged line-sized request out.
// Response side: one memory response in, routed back to the owning client lane.
// Modports:
//   slave  - arbiter view (consumes client requests and memory responses)
//   master - environment view (clients + memory model)
interface vx_mem_arb_tracked_if #(
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_SIZE  = 64,
    parameter int unsigned TAG_WIDTH  = 8
);
    localparam int unsigned LOG_IN     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned OTAG_WIDTH = TAG_WIDTH + LOG_IN;
    localparam int unsigned DATA_W     = DATA_SIZE * 8;

    // client request lanes
    logic [NUM_INPUTS-1:0]            req_valid_in;
    logic [NUM_INPUTS-1:0]            req_rw_in;
    logic [NUM_INPUTS*ADDR_WIDTH-1:0] req_addr_in;
    logic [NUM_INPUTS*DATA_SIZE-1:0]  req_byteen_in;
    logic [NUM_INPUTS*DATA_W-1:0]     req_data_in;
    logic [NUM_INPUTS*TAG_WIDTH-1:0]  req_tag_in;
    logic [NUM_INPUTS-1:0]            req_ready_in;

    // merged memory request
    logic                             req_valid_out;
    logic                             req_rw_out;
    logic [ADDR_WIDTH-1:0]            req_addr_out;
    logic [DATA_SIZE-1:0]             req_byteen_out;
    logic [DATA_W-1:0]                req_data_out;
    logic [OTAG_WIDTH-1:0]            req_tag_out;
    logic                             req_ready_out;

    // memory response
    logic                             rsp_valid_in;
    logic [DATA_W-1:0]                rsp_data_in;
    logic [OTAG_WIDTH-1:0]            rsp_tag_in;
    logic                             rsp_ready_in;

    // client response lanes
    logic [NUM_INPUTS-1:0]            rsp_valid_out;
    logic [NUM_INPUTS*DATA_W-1:0]     rsp_data_out;
    logic [NUM_INPUTS*TAG_WIDTH-1:0]  rsp_tag_out;
    logic [NUM_INPUTS-1:0]            rsp_ready_out;

    modport slave (
        input  req_valid_in, req_rw_in, req_addr_in, req_byteen_in, req_data_in, req_tag_in,
        output req_ready_in,
        output req_valid_out, req_rw_out, req_addr_out, req_byteen_out, req_data_out, req_tag_out,
        input  req_ready_out,
        input  rsp_valid_in, rsp_data_in, rsp_tag_in,
        output rsp_ready_in,
        output rsp_valid_out, rsp_data_out, rsp_tag_out,
        input  rsp_ready_out
    );

    modport master (
        output req_valid_in, req_rw_in, req_addr_in, req_byteen_in, req_data_in, req_tag_in,
        input  req_ready_in,
        input  req_valid_out, req_rw_out, req_addr_out, req_byteen_out, req_data_out, req_tag_out,
        output req_ready_out,
        output rsp_valid_in, rsp_data_in, rsp_tag_in,
        input  rsp_ready_in,
        input  rsp_valid_out, rsp_data_out, rsp_tag_out,
        output rsp_ready_out
    );
endinterface

// File: rtl/vx_mem_arb_tracked.sv
// N-input memory request arbiter with per-input outstanding-read tracking.
// Requests are granted (round-robin or fixed priority) into a one-entry output
// register; the source index is appended to the tag LSBs and used to route
// responses back. Reads per input are credit-limited to MAX_PENDING.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset
//   bus    - request/response bundle (slave modport)
//   busy   - registered: request staged or any read outstanding
module vx_mem_arb_tracked #(
    parameter int unsigned NUM_INPUTS  = 2,
    parameter int unsigned ADDR_WIDTH  = 26,
    parameter int unsigned DATA_SIZE   = 64,
    parameter int unsigned TAG_WIDTH   = 8,
    parameter int unsigned ARB_MODE    = 0,
    parameter int unsigned MAX_PENDING = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_mem_arb_tracked_if.slave   bus,
    output logic                  busy
);
    localparam int unsigned LOG_IN     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned OTAG_WIDTH = TAG_WIDTH + LOG_IN;
    localparam int unsigned DATA_W     = DATA_SIZE * 8;
    localparam int unsigned CNT_W      = $clog2(MAX_PENDING + 1);

    logic [CNT_W-1:0]      r_pend     [NUM_INPUTS];
    logic [CNT_W-1:0]      w_pend_nxt [NUM_INPUTS];
    logic [LOG_IN-1:0]     r_ptr;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_SIZE-1:0]  r_byteen;
    logic [DATA_W-1:0]     r_data;
    logic [OTAG_WIDTH-1:0] r_tag;

    logic [NUM_INPUTS-1:0] w_elig;
    logic [NUM_INPUTS-1:0] w_inc;
    logic [NUM_INPUTS-1:0] w_dec;
    logic [NUM_INPUTS-1:0] w_rsp_valid;
    logic [LOG_IN-1:0]     w_win;
    logic [LOG_IN-1:0]     w_idx;
    logic                  w_any;
    logic                  w_can_load;
    logic                  w_fire;
    logic                  w_valid_nxt;
    logic                  w_busy_nxt;
    logic                  w_idx_ok;
    logic                  w_rsp_rdy;

    // Eligibility: valid and below the per-input credit limit (reads and writes alike)
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            w_elig[i] = bus.req_valid_in[i] && (r_pend[i] < CNT_W'(MAX_PENDING));
        end
    end

    // Grant selection among eligible inputs
    always_comb begin : p_grant
        int j;
        j     = 0;
        w_any = 1'b0;
        w_win = '0;
        if (ARB_MODE == 1) begin
            // descending scan so the lowest eligible index is the last written
            for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
                if (w_elig[i]) begin
                    w_any = 1'b1;
                    w_win = LOG_IN'(i);
                end
            end
        end else begin
            for (int k = 0; k < int'(NUM_INPUTS); k++) begin
                j = int'(r_ptr) + k;
                if (j >= int'(NUM_INPUTS)) begin
                    j = j - int'(NUM_INPUTS);
                end
                if (!w_any && w_elig[j]) begin
                    w_any = 1'b1;
                    w_win = LOG_IN'(j);
                end
            end
        end
    end

    assign w_can_load  = !r_valid || bus.req_ready_out;
    assign w_fire      = w_any && w_can_load;
    assign w_valid_nxt = w_fire || (r_valid && !bus.req_ready_out);

    // One-hot accept toward the granted client
    always_comb begin
        bus.req_ready_in = '0;
        if (w_fire) begin
            bus.req_ready_in[w_win] = 1'b1;
        end
    end

    // Response routing by tag index; out-of-range indices are accepted and dropped
    assign w_idx = bus.rsp_tag_in[LOG_IN-1:0];

    if (NUM_INPUTS == (32'd1 << LOG_IN)) begin : g_idx_full
        assign w_idx_ok = 1'b1;
    end else begin : g_idx_part
        assign w_idx_ok = (w_idx < LOG_IN'(NUM_INPUTS));
    end

    always_comb begin
        w_rsp_valid = '0;
        w_dec       = '0;
        w_rsp_rdy   = !w_idx_ok;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            if (w_idx == LOG_IN'(i)) begin
                w_rsp_valid[i] = bus.rsp_valid_in;
                w_rsp_rdy      = w_rsp_rdy | bus.rsp_ready_out[i];
                w_dec[i]       = bus.rsp_valid_in && bus.rsp_ready_out[i];
            end
        end
    end

    assign bus.rsp_valid_out = w_rsp_valid;
    assign bus.rsp_ready_in  = w_rsp_rdy;
    assign bus.rsp_data_out  = {NUM_INPUTS{bus.rsp_data_in}};
    assign bus.rsp_tag_out   = {NUM_INPUTS{bus.rsp_tag_in[OTAG_WIDTH-1:LOG_IN]}};

    // Next pending counts; simultaneous inc/dec cancels, decrement saturates at 0
    always_comb begin
        w_inc      = '0;
        w_busy_nxt = w_valid_nxt;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            w_inc[i]      = w_fire && (w_win == LOG_IN'(i)) && !bus.req_rw_in[i];
            w_pend_nxt[i] = r_pend[i];
            if (w_inc[i] && !w_dec[i]) begin
                w_pend_nxt[i] = r_pend[i] + CNT_W'(1);
            end else if (!w_inc[i] && w_dec[i] && (r_pend[i] != '0)) begin
                w_pend_nxt[i] = r_pend[i] - CNT_W'(1);
            end
            if (w_pend_nxt[i] != '0) begin
                w_busy_nxt = 1'b1;
            end
        end
    end

    // Control state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            if ((ARB_MODE == 0) && w_fire) begin
                r_ptr <= (w_win == LOG_IN'(NUM_INPUTS - 1)) ? '0 : w_win + 1'b1;
            end
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                r_pend[i] <= w_pend_nxt[i];
            end
        end
    end

    // Payload register; contents are don't-care while r_valid is low
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_rw     <= bus.req_rw_in[w_win];
            r_addr   <= bus.req_addr_in[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
            r_byteen <= bus.req_byteen_in[int'(w_win)*DATA_SIZE +: DATA_SIZE];
            r_data   <= bus.req_data_in[int'(w_win)*DATA_W +: DATA_W];
            r_tag    <= {bus.req_tag_in[int'(w_win)*TAG_WIDTH +: TAG_WIDTH], w_win};
        end
    end

    assign bus.req_valid_out  = r_valid;
    assign bus.req_rw_out     = r_rw;
    assign bus.req_addr_out   = r_addr;
    assign bus.req_byteen_out = r_byteen;
    assign bus.req_data_out   = r_data;
    assign bus.req_tag_out    = r_tag;
    assign busy               = r_busy;

    // A response must carry the index of an existing client
    a_rsp_idx: assert property (@(posedge clk) disable iff (!reset)
        bus.rsp_valid_in |-> w_idx_ok);

endmodule
